// File: rtl/ps2_calc_core.sv
// Keyboard calculator core: PS/2 set-2 scan bytes in, BCD display bus out.
// Two decimal operands, sequential +,-,*,/ datapaths with busy/latency contract.
module ps2_calc_core #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned BIN_W  = 24
) (
  input  logic                  clk,
  input  logic                  iRST_n,
  input  logic                  iKEY_VALID,
  input  logic [7:0]            iKEY_CODE,
  output logic [4*DIGITS-1:0]   oDISP_BCD,
  output logic                  oNEG,
  output logic                  oERR,
  output logic                  oBUSY,
  output logic [2:0]            oSTATE
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned PW = 2 * BIN_W;
  localparam int unsigned CW = $clog2(BIN_W + DIGITS);
  localparam int unsigned NW = $clog2(DIGITS + 1);

  function automatic logic [PW-1:0] pow10(input int unsigned n);
    logic [PW-1:0] v;
    v = PW'(1);
    for (int unsigned i = 0; i < n; i++) v = v * PW'(10);
    return v;
  endfunction

  localparam logic [PW-1:0] MAX_POS = pow10(DIGITS) - PW'(1);
  localparam logic [PW-1:0] MAX_NEG = pow10(DIGITS - 1) - PW'(1);

  function automatic logic [DW-1:0] dd_adj(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_OPA = 3'd1, S_OPB = 3'd2, S_CALC = 3'd3, S_RESULT = 3'd4, S_ERROR = 3'd5
  } state_t;
  typedef enum logic [1:0] {PH_CONV, PH_EXEC, PH_CHK, PH_B2D} phase_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t          state;
  phase_t          phase;
  op_t             op;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   a_bcd, b_bcd, r_bcd, m_bcd;
  logic [NW-1:0]   a_cnt, b_cnt;
  logic [BIN_W-1:0] a_bin, b_bin, rem, sh_q, sh_r;
  logic [PW-1:0]   acc;
  logic            neg, show_rem, brk;

  // Key decode
  logic       k_digit, k_op, k_enter, k_bksp, k_esc, k_space;
  logic [3:0] k_val;
  op_t        k_opv;
  always_comb begin
    k_digit = 1'b0; k_op = 1'b0; k_enter = 1'b0; k_bksp = 1'b0;
    k_esc = 1'b0; k_space = 1'b0; k_val = 4'd0; k_opv = OP_ADD;
    case (iKEY_CODE)
      8'h70: begin k_digit = 1'b1; k_val = 4'd0; end
      8'h69: begin k_digit = 1'b1; k_val = 4'd1; end
      8'h72: begin k_digit = 1'b1; k_val = 4'd2; end
      8'h7A: begin k_digit = 1'b1; k_val = 4'd3; end
      8'h6B: begin k_digit = 1'b1; k_val = 4'd4; end
      8'h73: begin k_digit = 1'b1; k_val = 4'd5; end
      8'h74: begin k_digit = 1'b1; k_val = 4'd6; end
      8'h6C: begin k_digit = 1'b1; k_val = 4'd7; end
      8'h75: begin k_digit = 1'b1; k_val = 4'd8; end
      8'h7D: begin k_digit = 1'b1; k_val = 4'd9; end
      8'h79: begin k_op = 1'b1; k_opv = OP_ADD; end
      8'h7B: begin k_op = 1'b1; k_opv = OP_SUB; end
      8'h7C: begin k_op = 1'b1; k_opv = OP_MUL; end
      8'h4A: begin k_op = 1'b1; k_opv = OP_DIV; end
      8'h5A: k_enter = 1'b1;
      8'h66: k_bksp  = 1'b1;
      8'h76: k_esc   = 1'b1;
      8'h29: k_space = 1'b1;
      default: ;
    endcase
  end

  // Prefixed and plain codes decode identically, so the E0 byte is simply consumed.
  logic key_act, do_clr;
  assign key_act = iKEY_VALID && !brk && (iKEY_CODE != 8'hF0) && (iKEY_CODE != 8'hE0);
  assign do_clr  = key_act && (k_esc || (k_enter && state != S_OPB && state != S_CALC));

  // MSD-first digit pick during conversion; restoring-divider trial subtract
  logic [3:0]     a_dig, b_dig;
  logic [BIN_W:0] r_sh;
  logic [BIN_W-1:0] r_sub;
  logic           r_ge, chk_err;
  logic [DW-1:0]  r_adj, m_adj;
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (CW'(DIGITS - 1 - i) == cnt) begin
        a_dig = a_bcd[4*i +: 4];
        b_dig = b_bcd[4*i +: 4];
      end
    end
    r_sh    = {rem, a_bin[BIN_W-1]};
    r_ge    = r_sh >= {1'b0, b_bin};
    r_sub   = r_sh[BIN_W-1:0] - b_bin;
    chk_err = (op == OP_DIV && b_bin == '0) || (acc > MAX_POS) ||
              (neg && acc > MAX_NEG) || (op == OP_MUL && |acc[PW-1:BIN_W]);
    r_adj   = dd_adj(r_bcd);
    m_adj   = dd_adj(m_bcd);
  end

  always_ff @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= S_IDLE; phase <= PH_CONV; op <= OP_ADD; cnt <= '0;
      a_bcd <= '0; b_bcd <= '0; r_bcd <= '0; m_bcd <= '0;
      a_cnt <= '0; b_cnt <= '0;
      a_bin <= '0; b_bin <= '0; rem <= '0; sh_q <= '0; sh_r <= '0; acc <= '0;
      neg <= 1'b0; show_rem <= 1'b0; brk <= 1'b0;
    end else begin
      if (iKEY_VALID) begin
        if (iKEY_CODE == 8'hF0) brk <= 1'b1;
        else if (brk)           brk <= 1'b0;
      end

      if (do_clr) begin
        state <= S_IDLE; phase <= PH_CONV; op <= OP_ADD; cnt <= '0;
        a_bcd <= '0; b_bcd <= '0; r_bcd <= '0; m_bcd <= '0;
        a_cnt <= '0; b_cnt <= '0;
        a_bin <= '0; b_bin <= '0; rem <= '0; sh_q <= '0; sh_r <= '0; acc <= '0;
        neg <= 1'b0; show_rem <= 1'b0;
      end else if (state == S_CALC) begin
        case (phase)
          PH_CONV: begin
            a_bin <= (a_bin << 3) + (a_bin << 1) + BIN_W'(a_dig);
            b_bin <= (b_bin << 3) + (b_bin << 1) + BIN_W'(b_dig);
            if (cnt == CW'(DIGITS - 1)) begin phase <= PH_EXEC; cnt <= '0; end
            else cnt <= cnt + 1'b1;
          end
          PH_EXEC: begin
            case (op)
              OP_ADD: begin acc <= PW'(a_bin) + PW'(b_bin); phase <= PH_CHK; end
              OP_SUB: begin
                if (a_bin < b_bin) begin acc <= PW'(b_bin - a_bin); neg <= 1'b1; end
                else acc <= PW'(a_bin - b_bin);
                phase <= PH_CHK;
              end
              OP_MUL: acc <= acc + (b_bin[cnt] ? (PW'(a_bin) << cnt) : '0);
              OP_DIV: begin
                rem   <= r_ge ? r_sub : r_sh[BIN_W-1:0];
                acc   <= {acc[PW-2:0], r_ge};
                a_bin <= a_bin << 1;
              end
            endcase
            if (op == OP_MUL || op == OP_DIV) begin
              if (cnt == CW'(BIN_W - 1)) begin phase <= PH_CHK; cnt <= '0; end
              else cnt <= cnt + 1'b1;
            end
          end
          PH_CHK: begin
            if (chk_err) state <= S_ERROR;
            phase <= PH_B2D; cnt <= '0;
            sh_q <= acc[BIN_W-1:0]; sh_r <= rem;
            r_bcd <= '0; m_bcd <= '0;
          end
          PH_B2D: begin
            r_bcd <= {r_adj[DW-2:0], sh_q[BIN_W-1]};
            m_bcd <= {m_adj[DW-2:0], sh_r[BIN_W-1]};
            sh_q  <= sh_q << 1;
            sh_r  <= sh_r << 1;
            if (cnt == CW'(BIN_W - 1)) begin state <= S_RESULT; cnt <= '0; end
            else cnt <= cnt + 1'b1;
          end
        endcase
      end else if (key_act) begin
        case (state)
          S_OPA: begin
            if (k_digit && a_cnt < NW'(DIGITS)) begin
              a_bcd <= {a_bcd[DW-5:0], k_val}; a_cnt <= a_cnt + 1'b1;
            end else if (k_bksp) begin
              a_bcd <= {4'h0, a_bcd[DW-1:4]};
              if (a_cnt != '0) a_cnt <= a_cnt - 1'b1;
            end else if (k_op) begin
              op <= k_opv; b_bcd <= '0; b_cnt <= '0; state <= S_OPB;
            end
          end
          S_OPB: begin
            if (k_digit && b_cnt < NW'(DIGITS)) begin
              b_bcd <= {b_bcd[DW-5:0], k_val}; b_cnt <= b_cnt + 1'b1;
            end else if (k_bksp) begin
              b_bcd <= {4'h0, b_bcd[DW-1:4]};
              if (b_cnt != '0) b_cnt <= b_cnt - 1'b1;
            end else if (k_op) begin
              op <= k_opv;
            end else if (k_enter) begin
              state <= S_CALC; phase <= PH_CONV; cnt <= '0;
              a_bin <= '0; b_bin <= '0; acc <= '0; rem <= '0;
              neg <= 1'b0; show_rem <= 1'b0;
            end
          end
          default: begin
            if (k_digit) begin
              a_bcd <= DW'(k_val); a_cnt <= NW'(1);
              b_bcd <= '0; b_cnt <= '0;
              neg <= 1'b0; show_rem <= 1'b0; state <= S_OPA;
            end else if (state == S_RESULT && k_op && !neg && !show_rem) begin
              a_bcd <= r_bcd; a_cnt <= NW'(DIGITS);
              b_bcd <= '0; b_cnt <= '0; op <= k_opv; state <= S_OPB;
            end else if (state == S_RESULT && k_space && op == OP_DIV) begin
              show_rem <= !show_rem;
            end
          end
        endcase
      end
    end
  end

  logic [DW-1:0] sel_bcd;
  always_comb begin
    sel_bcd   = show_rem ? m_bcd : r_bcd;
    oDISP_BCD = a_bcd;
    oNEG      = 1'b0;
    oERR      = 1'b0;
    case (state)
      S_ERROR: begin oDISP_BCD = DW'(4'hE); oERR = 1'b1; end
      S_RESULT: begin
        if (neg) begin oDISP_BCD = {4'hF, sel_bcd[DW-5:0]}; oNEG = 1'b1; end
        else oDISP_BCD = sel_bcd;
      end
      S_OPB, S_CALC: oDISP_BCD = b_bcd;
      default: ;
    endcase
  end

  assign oBUSY  = (state == S_CALC);
  assign oSTATE = state;

endmodule

// File: tb/tb_ps2_calc_core.sv
// Directed bench for ps2_calc_core: scan-byte sequences with hand-computed results.
module tb_ps2_calc_core;
  localparam int unsigned DIGITS = 6;
  localparam int unsigned BIN_W  = 24;

  typedef logic [7:0] kq_t[$];

  logic        clk = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iKEY_VALID = 1'b0;
  logic [7:0]  iKEY_CODE = 8'h00;
  logic [4*DIGITS-1:0] oDISP_BCD;
  logic        oNEG, oERR, oBUSY;
  logic [2:0]  oSTATE;
  int          total = 0;
  int          bad = 0;
  int          n;

  ps2_calc_core #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .iRST_n(iRST_n), .iKEY_VALID(iKEY_VALID), .iKEY_CODE(iKEY_CODE),
    .oDISP_BCD(oDISP_BCD), .oNEG(oNEG), .oERR(oERR), .oBUSY(oBUSY), .oSTATE(oSTATE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic key(input logic [7:0] c);
    @(negedge clk);
    iKEY_CODE  = c;
    iKEY_VALID = 1'b1;
    @(negedge clk);
    iKEY_VALID = 1'b0;
  endtask

  task automatic keys(input kq_t s);
    foreach (s[i]) key(s[i]);
  endtask

  // Counts busy cycles sampled on falling edges; a stuck busy ends at the bound.
  task automatic wait_calc(output int cyc);
    cyc = 0;
    while (oBUSY === 1'b1 && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_disp", oDISP_BCD, 0);
    check("rst_flags", {oNEG, oERR, oBUSY}, 0);
    check("rst_state", oSTATE, 0);
    iRST_n = 1'b1;

    // 12 + 3 with break codes interleaved
    keys('{8'h69, 8'hF0, 8'h69, 8'h72, 8'hF0, 8'h72, 8'h79, 8'hF0, 8'h79,
           8'h7A, 8'hF0, 8'h7A, 8'h5A});
    wait_calc(n);
    check("add_lat", n, 32);
    check("add_disp", oDISP_BCD, 24'h000015);
    check("add_neg", oNEG, 0);
    check("add_state", oSTATE, 4);

    // 3 - 7
    keys('{8'h7A, 8'h7B, 8'h6C, 8'h5A});
    wait_calc(n);
    check("sub_disp", oDISP_BCD, 24'hF00004);
    check("sub_neg", oNEG, 1);
    keys('{8'hF0, 8'h5A});
    check("brk_enter", oSTATE, 4);

    // 999 * 99, then chain * 2
    keys('{8'h7D, 8'h7D, 8'h7D, 8'h7C, 8'h7D, 8'h7D, 8'h5A});
    wait_calc(n);
    check("mul_lat", n, 55);
    check("mul_disp", oDISP_BCD, 24'h098901);
    key(8'h7C);
    check("chain_state", oSTATE, 2);
    check("chain_disp", oDISP_BCD, 0);
    keys('{8'h72, 8'h5A});
    check("busy_show_b", oDISP_BCD, 24'h000002);
    wait_calc(n);
    check("chain_lat", n, 55);
    check("chain_disp2", oDISP_BCD, 24'h197802);

    // 9 / 2 via E0-prefixed keypad keys, then quotient/remainder toggle
    keys('{8'h7D, 8'hE0, 8'h4A, 8'h72, 8'hE0, 8'h5A});
    wait_calc(n);
    check("div_q", oDISP_BCD, 24'h000004);
    key(8'h29);
    check("div_r", oDISP_BCD, 24'h000001);
    key(8'h29);
    check("div_q2", oDISP_BCD, 24'h000004);

    // divide by zero, recovery by digit
    keys('{8'h73, 8'h4A, 8'h70, 8'h5A});
    wait_calc(n);
    check("dz_err", oERR, 1);
    check("dz_disp", oDISP_BCD, 24'h00000E);
    check("dz_state", oSTATE, 5);
    key(8'h69);
    check("rec_state", oSTATE, 1);
    check("rec_disp", oDISP_BCD, 24'h000001);
    check("rec_err", oERR, 0);

    // range boundaries
    key(8'h76);
    keys('{8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h79, 8'h70, 8'h5A});
    wait_calc(n);
    check("max_pos", oDISP_BCD, 24'h999999);
    key(8'h5A);
    check("enter_idle", oSTATE, 0);
    keys('{8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h79, 8'h69, 8'h5A});
    wait_calc(n);
    check("ovf_err", oERR, 1);
    keys('{8'h70, 8'h7B, 8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h7D, 8'h5A});
    wait_calc(n);
    check("max_neg", oDISP_BCD, 24'hF99999);
    check("max_neg_n", oNEG, 1);
    keys('{8'h70, 8'h7B, 8'h69, 8'h70, 8'h70, 8'h70, 8'h70, 8'h70, 8'h5A});
    wait_calc(n);
    check("neg_ovf", oERR, 1);

    // digit limit, backspace, Esc mid-calculation
    key(8'h76);
    repeat (8) key(8'h6C);
    check("limit", oDISP_BCD, 24'h777777);
    key(8'h66);
    check("bksp", oDISP_BCD, 24'h077777);
    keys('{8'h79, 8'h72, 8'h5A});
    repeat (5) @(negedge clk);
    check("busy_mid", oBUSY, 1);
    key(8'h76);
    check("esc_state", oSTATE, 0);
    check("esc_disp", oDISP_BCD, 0);
    check("esc_flags", {oNEG, oERR, oBUSY}, 0);

    // asynchronous reset mid-calculation
    keys('{8'h72, 8'h79, 8'h72, 8'h5A});
    repeat (4) @(negedge clk);
    iRST_n = 1'b0;
    #1;
    check("arst_state", oSTATE, 0);
    check("arst_outs", {oDISP_BCD, oNEG, oERR, oBUSY}, 0);
    @(negedge clk);
    iRST_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
